// File: rtl/bitmux4to1_rr.sv
// -----------------------------------------------------------------------------
// bitmux4to1_rr
//
// Four-lane to one-lane symbol collector. Each lane presents a W-bit symbol
// with its own valid/ready handshake. One pending lane is granted per cycle,
// and its symbol is loaded into a single registered output stage together
// with its lane index.
//
// Build option:
//   BITMUX_FIXED_PRIORITY_EN  - when defined, the search always starts at
//                               lane 0 (lane 0 highest, lane 3 lowest) and no
//                               rotating pointer is implemented. When
//                               undefined, arbitration is round-robin: the
//                               search starts at the lane after the last
//                               granted one.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   z_in       packed lane data, lane i = z_in[W*i +: W]
//   z_valid    per-lane valid
//   z_ready    per-lane ready, one-hot or zero, combinational
//   a_out      collected symbol (registered)
//   s_out      lane index of a_out (registered)
//   a_valid    output symbol valid (registered)
//   a_ready    downstream ready
//   sym_count  count of accepted symbols, wraps 255 -> 0
// -----------------------------------------------------------------------------
module bitmux4to1_rr #(
    parameter int W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4*W-1:0]   z_in,
    input  logic [3:0]       z_valid,
    output logic [3:0]       z_ready,
    output logic [W-1:0]     a_out,
    output logic [1:0]       s_out,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [7:0]       sym_count
);

    // Output holding register and counter
    logic [W-1:0] a_out_q,     a_out_d;
    logic [1:0]   s_out_q,     s_out_d;
    logic         a_valid_q,   a_valid_d;
    logic [7:0]   sym_count_q, sym_count_d;

    // Arbitration
    logic [1:0]   search_base;
    logic [7:0]   valid_dbl;
    logic [3:0]   valid_rot;
    logic [1:0]   grant_off;
    logic [1:0]   grant;
    logic         any_valid;
    logic         can_load;
    logic         do_grant;
    logic [W-1:0] grant_data;

`ifdef BITMUX_FIXED_PRIORITY_EN
    assign search_base = 2'd0;
`else
    logic [1:0] ptr_q, ptr_d;

    assign search_base = ptr_q;

    always_comb begin
        ptr_d = ptr_q;
        if (do_grant) begin
            ptr_d = grant + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // The load slot is free when empty, or when the held symbol leaves this
    // cycle; a drain and a new load in the same cycle leave no bubble.
    assign can_load  = !a_valid_q || a_ready;
    assign any_valid = |z_valid;
    assign do_grant  = can_load && any_valid && !rst;

    // Rotate the valid vector so that the search start lands on bit 0, pick
    // the lowest set bit, then rotate the offset back into a lane number.
    assign valid_dbl = {z_valid, z_valid};

    always_comb begin
        valid_rot = valid_dbl[search_base +: 4];
    end

    always_comb begin
        grant_off = 2'd3;
        if (valid_rot[0]) begin
            grant_off = 2'd0;
        end else if (valid_rot[1]) begin
            grant_off = 2'd1;
        end else if (valid_rot[2]) begin
            grant_off = 2'd2;
        end
    end

    assign grant = search_base + grant_off;

    always_comb begin
        grant_data = z_in[W-1:0];
        case (grant)
            2'd0:    grant_data = z_in[W-1:0];
            2'd1:    grant_data = z_in[2*W-1:W];
            2'd2:    grant_data = z_in[3*W-1:2*W];
            default: grant_data = z_in[4*W-1:3*W];
        endcase
    end

    // Ready is withheld during reset so no upstream symbol is consumed then.
    always_comb begin
        z_ready = 4'b0000;
        if (do_grant) begin
            z_ready = 4'b0001 << grant;
        end
    end

    always_comb begin
        a_out_d     = a_out_q;
        s_out_d     = s_out_q;
        a_valid_d   = a_valid_q;
        sym_count_d = sym_count_q;
        if (do_grant) begin
            a_out_d     = grant_data;
            s_out_d     = grant;
            a_valid_d   = 1'b1;
            sym_count_d = sym_count_q + 8'd1;
        end else if (can_load && a_ready) begin
            // Drained with nothing to replace it; data/index keep last values.
            a_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_out_q     <= '0;
            s_out_q     <= 2'd0;
            a_valid_q   <= 1'b0;
            sym_count_q <= 8'd0;
        end else begin
            a_out_q     <= a_out_d;
            s_out_q     <= s_out_d;
            a_valid_q   <= a_valid_d;
            sym_count_q <= sym_count_d;
        end
    end

    assign a_out     = a_out_q;
    assign s_out     = s_out_q;
    assign a_valid   = a_valid_q;
    assign sym_count = sym_count_q;

endmodule

// File: tb/tb_bitmux4to1_rr.sv
// -----------------------------------------------------------------------------
// tb_bitmux4to1_rr
//
// Drives a table of hand-derived vectors, then random traffic, then a counter
// wrap sequence. A behavioural reference model runs alongside every cycle:
// granted symbols are pushed into a scoreboard queue and popped/compared
// when the DUT hands a symbol downstream. Honours BITMUX_FIXED_PRIORITY_EN.
// -----------------------------------------------------------------------------
module tb_bitmux4to1_rr;

    localparam int W = 2;

    logic           clk;
    logic           rst;
    logic [4*W-1:0] z_in;
    logic [3:0]     z_valid;
    logic [3:0]     z_ready;
    logic [W-1:0]   a_out;
    logic [1:0]     s_out;
    logic           a_valid;
    logic           a_ready;
    logic [7:0]     sym_count;

    bitmux4to1_rr #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .z_in      (z_in),
        .z_valid   (z_valid),
        .z_ready   (z_ready),
        .a_out     (a_out),
        .s_out     (s_out),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .sym_count (sym_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] zin;
        logic [3:0] zv;
        logic       ar;
        logic [3:0] zr;
        logic       av;
        logic [1:0] a;
        logic [1:0] s;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic       m_valid = 1'b0;
    logic [1:0] m_a     = 2'd0;
    logic [1:0] m_s     = 2'd0;
    logic [7:0] m_cnt   = 8'd0;
    logic [1:0] m_ptr   = 2'd0;
    logic [3:0] sbq[$];   // {lane, data}

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [7:0] zin, input logic [3:0] zv,
                                input logic ar, input logic [3:0] zr, input logic av,
                                input logic [1:0] a, input logic [1:0] s, input logic [7:0] cnt);
        vec_t v;
        v.rst = r; v.zin = zin; v.zv = zv; v.ar = ar; v.zr = zr;
        v.av = av; v.a = a; v.s = s; v.cnt = cnt;
        return v;
    endfunction

    task automatic step(input logic r, input logic [7:0] zin, input logic [3:0] zv,
                        input logic ar, input bit use_exp, input vec_t e);
        logic       can;
        logic       found;
        logic [1:0] g;
        logic [1:0] lane;
        logic [1:0] base;
        logic [3:0] exp_zr;
        logic [3:0] ent;

        @(negedge clk);
        rst = r; z_in = zin; z_valid = zv; a_ready = ar;
        #1;

`ifdef BITMUX_FIXED_PRIORITY_EN
        base = 2'd0;
`else
        base = m_ptr;
`endif
        found = 1'b0;
        g = 2'd0;
        for (int k = 0; k < 4; k++) begin
            lane = base + 2'(k);
            if (!found && zv[lane]) begin
                found = 1'b1;
                g = lane;
            end
        end
        can = !m_valid || ar;
        exp_zr = (!r && can && found) ? (4'b0001 << g) : 4'b0000;
        chk("z_ready_model", {4'h0, z_ready}, {4'h0, exp_zr});
        if (use_exp) chk("z_ready_tbl", {4'h0, z_ready}, {4'h0, e.zr});

        // Downstream transfer at this edge: pop the oldest granted symbol
        if (!r && a_valid === 1'b1 && ar) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 8'd1, 8'd0);
            end else begin
                ent = sbq.pop_front();
                chk("sb_symbol", {4'h0, s_out, a_out}, {4'h0, ent});
            end
        end

        if (r) begin
            m_valid = 1'b0; m_a = 2'd0; m_s = 2'd0; m_cnt = 8'd0; m_ptr = 2'd0;
            sbq.delete();
        end else if (can) begin
            if (found) begin
                m_valid = 1'b1;
                m_a = zin[2*g +: 2];
                m_s = g;
                m_cnt = m_cnt + 8'd1;
                m_ptr = g + 2'd1;
                sbq.push_back({g, m_a});
            end else if (ar) begin
                m_valid = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        chk("a_valid_model", {7'd0, a_valid}, {7'd0, m_valid});
        chk("sym_count_model", sym_count, m_cnt);
        if (m_valid) chk("a_out_s_out_model", {4'h0, s_out, a_out}, {4'h0, m_s, m_a});
        if (use_exp) begin
            chk("a_valid_tbl", {7'd0, a_valid}, {7'd0, e.av});
            chk("a_out_tbl", {6'd0, a_out}, {6'd0, e.a});
            chk("s_out_tbl", {6'd0, s_out}, {6'd0, e.s});
            chk("sym_count_tbl", sym_count, e.cnt);
        end
    endtask

    initial begin
        vec_t dummy;
        dummy = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1; z_in = 8'h00; z_valid = 4'h0; a_ready = 1'b0;

        // Reset, single lane, round-robin, backpressure, idle, mid-stream reset
        tbl.push_back(mk(1, 8'hE4, 4'hF, 1, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 8'hE4, 4'hF, 1, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'h04, 4'h2, 1, 4'h2, 1, 1, 1, 1));
        tbl.push_back(mk(1, 8'hE4, 4'h0, 1, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'hE4, 4'hF, 1, 4'h1, 1, 0, 0, 1));
`ifdef BITMUX_FIXED_PRIORITY_EN
        tbl.push_back(mk(0, 8'hE4, 4'hF, 1, 4'h1, 1, 0, 0, 2));
        tbl.push_back(mk(0, 8'hE4, 4'hF, 1, 4'h1, 1, 0, 0, 3));
        tbl.push_back(mk(0, 8'hE4, 4'hF, 1, 4'h1, 1, 0, 0, 4));
        tbl.push_back(mk(0, 8'hE4, 4'hF, 1, 4'h1, 1, 0, 0, 5));
`else
        tbl.push_back(mk(0, 8'hE4, 4'hF, 1, 4'h2, 1, 1, 1, 2));
        tbl.push_back(mk(0, 8'hE4, 4'hF, 1, 4'h4, 1, 2, 2, 3));
        tbl.push_back(mk(0, 8'hE4, 4'hF, 1, 4'h8, 1, 3, 3, 4));
        tbl.push_back(mk(0, 8'hE4, 4'hF, 1, 4'h1, 1, 0, 0, 5));
`endif
        tbl.push_back(mk(0, 8'hE4, 4'h4, 1, 4'h4, 1, 2, 2, 6));
        tbl.push_back(mk(0, 8'hE4, 4'hF, 0, 4'h0, 1, 2, 2, 6));
        tbl.push_back(mk(0, 8'hE4, 4'hF, 0, 4'h0, 1, 2, 2, 6));
        tbl.push_back(mk(0, 8'hE4, 4'hF, 0, 4'h0, 1, 2, 2, 6));
`ifdef BITMUX_FIXED_PRIORITY_EN
        tbl.push_back(mk(0, 8'hE4, 4'hF, 1, 4'h1, 1, 0, 0, 7));
        tbl.push_back(mk(0, 8'hE4, 4'h0, 1, 4'h0, 0, 0, 0, 7));
        tbl.push_back(mk(0, 8'hE4, 4'h0, 0, 4'h0, 0, 0, 0, 7));
`else
        tbl.push_back(mk(0, 8'hE4, 4'hF, 1, 4'h8, 1, 3, 3, 7));
        tbl.push_back(mk(0, 8'hE4, 4'h0, 1, 4'h0, 0, 3, 3, 7));
        tbl.push_back(mk(0, 8'hE4, 4'h0, 0, 4'h0, 0, 3, 3, 7));
`endif
        tbl.push_back(mk(0, 8'hE4, 4'h1, 0, 4'h1, 1, 0, 0, 8));
        tbl.push_back(mk(0, 8'hE4, 4'hF, 0, 4'h0, 1, 0, 0, 8));
        tbl.push_back(mk(1, 8'hE4, 4'hF, 1, 4'h0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 8'hE4, 4'hF, 1, 4'h1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'hE4, 4'hC, 1, 4'h4, 1, 2, 2, 2));

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].zin, tbl[i].zv, tbl[i].ar, 1'b1, tbl[i]);
        end

        // Random traffic against the model and scoreboard
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), 8'($urandom), 4'($urandom),
                 ($urandom_range(0, 9) < 7), 1'b0, dummy);
        end

        // Counter wrap: 256 accepted symbols return sym_count to 0
        step(1'b1, 8'hE4, 4'hF, 1'b1, 1'b0, dummy);
        for (int i = 0; i < 255; i++) begin
            step(1'b0, 8'($urandom), 4'hF, 1'b1, 1'b0, dummy);
        end
        chk("sym_count_255", sym_count, 8'd255);
        step(1'b0, 8'hE4, 4'hF, 1'b1, 1'b0, dummy);
        chk("sym_count_wrap", sym_count, 8'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
